alu_cmd_driver: RTL and testbench

//  Command-side driver for the 4-bit ALU: accepts {sel,a,b} commands over valid/ready,

---
 rtl/alu_cmd_driver.sv | 119 +++++++++++
 tb/tb_alu_cmd_driver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready command driver for a combinational 4-bit ALU, one op in flight.
// Optional ALU_CMD_SELFCHECK_EN adds a result model with chk_err/err_count outputs.
module alu_cmd_driver #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_sel,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [4:0]       alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [4:0]       res_y,
  output logic [3:0]       res_sel,
  output logic             busy,
`ifdef ALU_CMD_SELFCHECK_EN
  output logic             chk_err,
  output logic [CNT_W-1:0] err_count,
`endif
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;
  state_t state;
  logic [3:0] cnt;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
`ifdef ALU_CMD_SELFCHECK_EN
  // Arithmetic ops see sign-extended operands, logical ops zero-extended.
  function automatic logic [4:0] model(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sa, sb, za, zb, r;
    sa = {a[3], a};
    sb = {b[3], b};
    za = {1'b0, a};
    zb = {1'b0, b};
    if (!s[3])
      case (s[2:0])
        3'd0: r = sa + 5'd1;
        3'd1: r = sa - 5'd1;
        3'd2: r = sb;
        3'd3: r = sb + 5'd1;
        3'd4: r = sb - 5'd1;
        3'd5: r = sa;
        3'd6: r = sa + sb;
        default: r = sa << 1;
      endcase
    else
      case (s[2:0])
        3'd0: r = ~za;
        3'd1: r = ~zb;
        3'd2: r = za & zb;
        3'd3: r = za | zb;
        3'd4: r = za ^ zb;
        3'd5: r = ~(za ^ zb);
        3'd6: r = ~(za & zb);
        default: r = ~(za | zb);
      endcase
    return r;
  endfunction
  logic mismatch;
  assign mismatch = alu_y != model(alu_sel, alu_a, alu_b);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err <= 1'b0;
      err_count <= '0;
    end else begin
      chk_err <= state == SETTLE && cnt == 4'd0 && mismatch;
      if (state == SETTLE && cnt == 4'd0 && mismatch && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      res_y <= '0;
      res_sel <= '0;
      res_valid <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE:
          if (cmd_valid) begin
            alu_a <= cmd_a;
            alu_b <= cmd_b;
            alu_sel <= cmd_sel;
            cnt <= 4'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end
        SETTLE:
          if (cnt == 4'd0) begin
            res_y <= alu_y;
            res_sel <= alu_sel;
            res_valid <= 1'b1;
            state <= RESULT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        RESULT:
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count <= op_count + 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed plus random ops against an arithmetic ALU/driver reference.
module tb_alu_cmd_driver;
  localparam int S = 3;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, res_valid, res_ready = 1'b0, busy;
  logic [3:0] cmd_sel = '0, cmd_a = '0, cmd_b = '0, alu_a, alu_b, alu_sel, res_sel;
  logic [4:0] alu_y, res_y;
  logic [W-1:0] op_count;
  logic force_zero = 1'b0;
  int compared = 0, mismatched = 0, exp_count = 0;
`ifdef ALU_CMD_SELFCHECK_EN
  logic chk_err;
  logic [W-1:0] err_count;
  int exp_err = 0;
`endif

  always #5 clk = ~clk;

  function automatic int sx(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Reference ALU: plain integer arithmetic reduced mod 32.
  function automatic logic [4:0] ref_y(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    int x, y, r;
    x = s[3] ? int'(a) : sx(a);
    y = s[3] ? int'(b) : sx(b);
    if (!s[3])
      case (s[2:0])
        0: r = x + 1;
        1: r = x - 1;
        2: r = y;
        3: r = y + 1;
        4: r = y - 1;
        5: r = x;
        6: r = x + y;
        default: r = x * 2;
      endcase
    else
      case (s[2:0])
        0: r = 31 - x;
        1: r = 31 - y;
        2: r = x & y;
        3: r = x | y;
        4: r = x ^ y;
        5: r = 31 - (x ^ y);
        6: r = 31 - (x & y);
        default: r = 31 - (x | y);
      endcase
    return 5'(r & 31);
  endfunction

  assign alu_y = force_zero ? 5'd0 : ref_y(alu_sel, alu_a, alu_b);

  alu_cmd_driver #(.SETTLE_CYCLES(S), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_sel(res_sel),
    .busy(busy),
`ifdef ALU_CMD_SELFCHECK_EN
    .chk_err(chk_err), .err_count(err_count),
`endif
    .op_count(op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b, input int hold);
    logic [4:0] y;
    y = force_zero ? 5'd0 : ref_y(s, a, b);
    @(negedge clk);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    cmd_valid = 1'b1;
    cmd_sel = s;
    cmd_a = a;
    cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("acc_busy", busy, 1);
    check("acc_ready", cmd_ready, 0);
    check("acc_alu", {alu_sel, alu_a, alu_b}, {s, a, b});
    check("acc_rvalid", res_valid, 0);
    for (int k = 1; k < S; k++) begin
      @(negedge clk);
      check("settle_rvalid", res_valid, 0);
    end
    @(negedge clk);
    check("cap_rvalid", res_valid, 1);
    check("cap_y", res_y, y);
    check("cap_sel", res_sel, s);
`ifdef ALU_CMD_SELFCHECK_EN
    if (y != ref_y(s, a, b) && exp_err < 255) exp_err++;
    check("chk_err_hi", chk_err, y != ref_y(s, a, b));
    check("err_count", err_count, exp_err);
`endif
    cmd_valid = 1'b1;
    cmd_sel = ~s;
    cmd_a = ~a;
    cmd_b = ~b;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_rvalid", res_valid, 1);
      check("hold_y", {res_sel, res_y}, {s, y});
      check("hold_ready", cmd_ready, 0);
      check("hold_alu", {alu_sel, alu_a, alu_b}, {s, a, b});
`ifdef ALU_CMD_SELFCHECK_EN
      check("chk_err_lo", chk_err, 0);
`endif
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    exp_count++;
    check("done_rvalid", res_valid, 0);
    check("done_count", op_count, exp_count % 256);
    check("done_ready", cmd_ready, 1);
    check("done_alu_hold", {alu_sel, alu_a, alu_b}, {s, a, b});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_outs", {res_valid, busy, res_y, res_sel, alu_a, alu_b, alu_sel}, 0);
    check("rst_count", op_count, 0);
    check("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    do_op(4'b0110, 4'b0111, 4'b0001, 0);
    do_op(4'b0001, 4'b1000, 4'b0000, 1);
    do_op(4'b0111, 4'b1001, 4'b0000, 0);
    do_op(4'b1000, 4'b0000, 4'b0000, 2);
    do_op(4'b1010, 4'b1100, 4'b1010, 0);
    do_op(4'b0110, 4'b1111, 4'b1000, 5);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_sel = 4'b0011;
    cmd_a = 4'b0101;
    cmd_b = 4'b0110;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {res_valid, busy, res_y, res_sel, alu_a, alu_b, alu_sel}, 0);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_ready", cmd_ready, 1);
    exp_count = 0;
`ifdef ALU_CMD_SELFCHECK_EN
    check("mid_rst_err", {chk_err, err_count}, 0);
    exp_err = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    do_op(4'b0011, 4'b0101, 4'b0110, 1);
`ifdef ALU_CMD_SELFCHECK_EN
    force_zero = 1'b1;
    do_op(4'b0110, 4'b0001, 4'b0001, 1);
    force_zero = 1'b0;
`endif
    for (int i = 0; i < 260; i++)
      do_op(4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
